muldiv_unit: RTL and testbench
==============================

# muldiv_unit

Iterative 32-bit multiply/divide unit for the pipelined MIPS core, sitting beside the execute stage and consuming the ALU operand buses. It implements mult, multu, div and divu with radix-2 shift-add and restoring division built on the shared adder components. It owns the architectural HI/LO registers and raises `busy` so hazard logic can stall mfhi/mflo and new mult/div issue.

## Interface
- `WIDTH`, 32, operand width; HI and LO are each WIDTH bits.
- `ph1`  in  1  single rising-edge clock.
- `reset`  in  1  asynchronous, active-high reset.
- `start`  in  1  begin operation `op` on `srca`/`srcb`.
- `op`  in  2  00 mult, 01 multu, 10 div, 11 divu.
- `srca`  in  WIDTH  multiplicand or dividend; also mthi/mtlo data.
- `srcb`  in  WIDTH  multiplier or divisor.
- `mthi`  in  1  write `srca` into HI.
- `mtlo`  in  1  write `srca` into LO.
- `flush`  in  1  abort the in-flight operation.
- `busy`  out  1  operation in progress.
- `done`  out  1  one-cycle pulse when HI/LO take a result.
- `hi`  out  WIDTH  HI register.
- `lo`  out  WIDTH  LO register.

## Operation
- States: IDLE, RUN, FIXUP. `busy` = (state != IDLE).
- IDLE, `start`=1, `flush`=0: latch operand magnitudes (absolute value for signed ops, raw for unsigned), record result signs, counter=0, go to RUN.
- RUN: one iteration per cycle. Counter increments; after WIDTH iterations go to FIXUP.
- FIXUP: apply sign correction, write HI/LO, pulse `done`, return to IDLE.
- Multiply: 2·WIDTH product. HI is the upper half, LO the lower half. Signed product is negated when operand signs differ.
- Divide: LO is the quotient, HI the remainder. Signed quotient is negated when signs differ. Remainder takes the dividend's sign.
- Divide by zero (any div op): LO = all ones, HI = raw `srca`.
- Signed overflow (0x80000000 / −1) falls out naturally: LO=0x80000000, HI=0.
- `start` while busy: ignored.
- `mthi`/`mtlo` while busy: ignored. In IDLE they write at the next edge, and both may be asserted together.
- `start` with `mthi`/`mtlo` in IDLE: start wins, moves ignored.
- `flush`: next edge forces IDLE. HI/LO are unchanged and `done` does not pulse. If asserted in IDLE, it blocks `start` that cycle.
- Reset: state IDLE, counter 0, `hi`=0, `lo`=0, `busy`=0, `done`=0. Reset mid-operation discards the operation.

## Timing
- Edge E0 samples `start`. `busy` is high from E0 through E(WIDTH+1).
- E1..E(WIDTH): iterations.
- E(WIDTH+1): HI/LO updated and `done`=1 for exactly one cycle. Latency is 33 cycles for WIDTH=32.
- A new `start` is accepted in the cycle right after `done` (back-to-back gap of zero idle cycles).
- mthi/mtlo take effect on the edge they are sampled (1-cycle latency to `hi`/`lo`).
- `hi`/`lo` are registered outputs with no combinational path from inputs.

## Configuration
- `MULDIV_DIVIDE_EN` defined: all four ops are supported.
- `MULDIV_DIVIDE_EN` undefined: divide datapath is omitted. `start` with `op[1]`=1 is ignored: no state change, `busy` stays 0, HI/LO unchanged, no `done`. Multiply behaviour is identical in both builds.

## Structure
- Shared package `muldiv_pkg`:
  - op encodings (MD_MULT, MD_MULTU, MD_DIV, MD_DIVU);
  - state enum (IDLE, RUN, FIXUP);
  - counter width constant clog2(WIDTH+1).
- Sub-module `muldiv_step`: combinational single iteration.
  - Conditional add for multiply, trial subtract for divide.
  - Built on the existing WIDTH+1-bit adder with carry.
  - Instantiated once.
- Negation in FIXUP reuses the increment component.

## Test plan
- multu 0xFFFFFFFF × 0xFFFFFFFF → HI=0xFFFFFFFE, LO=0x00000001. `done` exactly 33 edges after `start`, `busy` high throughout.
- mult −3 (0xFFFFFFFD) × 7 → HI=0xFFFFFFFF, LO=0xFFFFFFEB. Then div −7/2 → LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- divu 100/0 → LO=0xFFFFFFFF, HI=0x00000064. div 0x80000000/0xFFFFFFFF → LO=0x80000000, HI=0.
- mthi 0x1234 and mtlo 0x5678 in IDLE, then mult 2×3 with `flush` on RUN cycle 10 → `busy` low next edge, no `done`, HI=0x1234, LO=0x5678 retained.
- `start` and `mthi` pulsed while busy → ignored, result of the first op unaffected. `start` on the cycle after `done` → accepted.
- Async `reset` mid-RUN → `hi`/`lo`/`busy`/`done` = 0 immediately, without waiting for a clock edge. Without `MULDIV_DIVIDE_EN`, divu 10/3 → `busy` stays 0, HI/LO unchanged.

Source files
------------

// File: rtl/muldiv_pkg.sv
// -----------------------------------------------------------------------------
// muldiv_pkg
// Shared definitions for the iterative multiply/divide unit:
//   - operation encodings driven on the `op` bus
//   - controller state enum
//   - iteration counter width helper and default-width constants
//   - small decode helpers for the op field
// Configuration macro used by the unit: MULDIV_DIVIDE_EN (see muldiv_unit.sv).
// -----------------------------------------------------------------------------
package muldiv_pkg;

    localparam int MD_WIDTH = 32;

    // Counter must hold the value WIDTH, hence WIDTH+1 codes.
    function automatic int md_cnt_w(input int width);
        return $clog2(width + 1);
    endfunction

    localparam int MD_CNT_W = md_cnt_w(MD_WIDTH);

    typedef enum logic [1:0] {
        MD_MULT  = 2'b00,
        MD_MULTU = 2'b01,
        MD_DIV   = 2'b10,
        MD_DIVU  = 2'b11
    } md_op_e;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        RUN   = 2'b01,
        FIXUP = 2'b10
    } md_state_e;

    // Bit 0 clear selects the signed variant (mult, div).
    function automatic logic md_is_signed(input logic [1:0] op);
        return ~op[0];
    endfunction

    // Bit 1 set selects a divide.
    function automatic logic md_is_div(input logic [1:0] op);
        return op[1];
    endfunction

endpackage

// File: rtl/muldiv_step.sv
// -----------------------------------------------------------------------------
// muldiv_step
// One combinational radix-2 iteration of the multiply/divide datapath, built
// around a single WIDTH+1-bit adder with carry-in/carry-out.
//   Multiply (shift-add): if the multiplier LSB is set, add the multiplicand
//     into the upper half, then shift {carry, upper, lower} right by one.
//   Divide (restoring): shift {remainder, quotient} left by one and trial
//     subtract the divisor; keep the difference and shift in a 1 when no
//     borrow occurs, otherwise keep the shifted remainder and shift in a 0.
// Ports:
//   i_div      1      select divide iteration (0 = multiply)
//   i_hi       WIDTH  accumulator upper half / partial remainder
//   i_lo       WIDTH  multiplier (shifting out) / dividend-quotient
//   i_operand  WIDTH  multiplicand or divisor magnitude
//   o_hi       WIDTH  next upper half
//   o_lo       WIDTH  next lower half
// -----------------------------------------------------------------------------
module muldiv_step #(
    parameter int WIDTH = 32
) (
    input  logic             i_div,
    input  logic [WIDTH-1:0] i_hi,
    input  logic [WIDTH-1:0] i_lo,
    input  logic [WIDTH-1:0] i_operand,
    output logic [WIDTH-1:0] o_hi,
    output logic [WIDTH-1:0] o_lo
);

    logic [WIDTH:0] w_add_a;
    logic [WIDTH:0] w_add_b;
    logic [WIDTH:0] w_sum;
    logic           w_cin;
    logic           w_cout;

    // Shared WIDTH+1-bit adder with carry.
    assign {w_cout, w_sum} = {1'b0, w_add_a} + {1'b0, w_add_b}
                           + {{(WIDTH+1){1'b0}}, w_cin};

    // Adder operand selection.
    always_comb begin
        if (i_div) begin
            // Shifted partial remainder minus divisor, as a + ~b + 1.
            w_add_a = {i_hi, i_lo[WIDTH-1]};
            w_add_b = ~{1'b0, i_operand};
            w_cin   = 1'b1;
        end else begin
            w_add_a = {1'b0, i_hi};
            w_add_b = i_lo[0] ? {1'b0, i_operand} : '0;
            w_cin   = 1'b0;
        end
    end

    // Result formation. For divide, carry-out set means no borrow.
    always_comb begin
        if (i_div) begin
            o_hi = w_cout ? w_sum[WIDTH-1:0] : w_add_a[WIDTH-1:0];
            o_lo = {i_lo[WIDTH-2:0], w_cout};
        end else begin
            o_hi = w_sum[WIDTH:1];
            o_lo = {w_sum[0], i_lo[WIDTH-1:1]};
        end
    end

endmodule

// File: rtl/muldiv_unit.sv
// -----------------------------------------------------------------------------
// muldiv_unit
// Iterative WIDTH-bit multiply/divide unit beside the execute stage. Owns the
// architectural HI/LO registers. An accepted operation runs WIDTH iterations
// then one sign-fixup cycle that writes HI/LO and pulses done (33 cycles for
// WIDTH=32). busy is high whenever the controller is not IDLE.
// Configuration:
//   MULDIV_DIVIDE_EN defined   -> mult, multu, div, divu
//   MULDIV_DIVIDE_EN undefined -> divide omitted; div/divu starts are ignored
// Ports:
//   ph1    in   1      rising-edge clock
//   reset  in   1      asynchronous active-high reset
//   start  in   1      begin operation `op` on srca/srcb (IDLE only)
//   op     in   2      00 mult, 01 multu, 10 div, 11 divu
//   srca   in   WIDTH  multiplicand / dividend / mthi-mtlo data
//   srcb   in   WIDTH  multiplier / divisor
//   mthi   in   1      write srca into HI (IDLE, no start)
//   mtlo   in   1      write srca into LO (IDLE, no start)
//   flush  in   1      abort in-flight op; blocks start in IDLE
//   busy   out  1      operation in progress
//   done   out  1      one-cycle pulse when HI/LO take a result
//   hi     out  WIDTH  HI register
//   lo     out  WIDTH  LO register
// -----------------------------------------------------------------------------
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int WIDTH = MD_WIDTH
) (
    input  logic             ph1,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] srca,
    input  logic [WIDTH-1:0] srcb,
    input  logic             mthi,
    input  logic             mtlo,
    input  logic             flush,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CNT_W = md_cnt_w(WIDTH);

`ifdef MULDIV_DIVIDE_EN
    localparam bit DIV_EN = 1'b1;
`else
    localparam bit DIV_EN = 1'b0;
`endif

    // Two's-complement negation: invert and increment.
    function automatic logic [2*WIDTH-1:0] neg_dw(input logic [2*WIDTH-1:0] x);
        return ~x + {{(2*WIDTH-1){1'b0}}, 1'b1};
    endfunction

    function automatic logic [WIDTH-1:0] neg_w(input logic [WIDTH-1:0] x);
        logic [2*WIDTH-1:0] t;
        t = neg_dw({{WIDTH{1'b0}}, x});
        return t[WIDTH-1:0];
    endfunction

    md_state_e        r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0] r_hi;
    logic [WIDTH-1:0] r_lo;
    logic             r_done;
    logic [WIDTH-1:0] r_acc_hi;     // product upper half / partial remainder
    logic [WIDTH-1:0] r_acc_lo;     // multiplier-product low / quotient
    logic [WIDTH-1:0] r_operand;    // multiplicand or divisor magnitude
    logic             r_is_div;
    logic             r_neg_q;      // negate product / quotient
    logic             r_neg_r;      // negate remainder (dividend negative)
    logic             r_div_zero;

    logic             w_is_div;
    logic             w_accept;
    logic             w_a_neg;
    logic             w_b_neg;
    logic [WIDTH-1:0] w_a_mag;
    logic [WIDTH-1:0] w_b_mag;
    logic [WIDTH-1:0] w_step_hi;
    logic [WIDTH-1:0] w_step_lo;
    logic [2*WIDTH-1:0] w_prod;
    logic [WIDTH-1:0] w_res_hi;
    logic [WIDTH-1:0] w_res_lo;

    // Without the divide build, w_is_div is constant 0 and the divide
    // datapath below folds away.
    assign w_is_div = DIV_EN & md_is_div(op);
    assign w_accept = start & ~flush & (DIV_EN | ~md_is_div(op));

    assign w_a_neg = md_is_signed(op) & srca[WIDTH-1];
    assign w_b_neg = md_is_signed(op) & srcb[WIDTH-1];
    assign w_a_mag = w_a_neg ? neg_w(srca) : srca;
    assign w_b_mag = w_b_neg ? neg_w(srcb) : srcb;

    muldiv_step #(.WIDTH(WIDTH)) u_step (
        .i_div     (r_is_div),
        .i_hi      (r_acc_hi),
        .i_lo      (r_acc_lo),
        .i_operand (r_operand),
        .o_hi      (w_step_hi),
        .o_lo      (w_step_lo)
    );

    // Sign correction applied in FIXUP.
    // NOTE: every signal written here gets a default first so no latch is inferred.
    always_comb begin
        w_prod   = {r_acc_hi, r_acc_lo};
        w_res_hi = r_acc_hi;
        w_res_lo = r_acc_lo;
        if (r_is_div) begin
            // Divide by zero: quotient all ones; the remainder path already
            // reproduces the raw dividend once its sign is restored.
            w_res_lo = r_div_zero ? '1 : (r_neg_q ? neg_w(r_acc_lo) : r_acc_lo);
            w_res_hi = r_neg_r ? neg_w(r_acc_hi) : r_acc_hi;
        end else begin
            if (r_neg_q) begin
                w_prod = neg_dw({r_acc_hi, r_acc_lo});
            end
            w_res_hi = w_prod[2*WIDTH-1:WIDTH];
            w_res_lo = w_prod[WIDTH-1:0];
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register sees the pre-edge value of every other register.
    always_ff @(posedge ph1 or posedge reset) begin
        if (reset) begin
            r_state    <= IDLE;
            r_cnt      <= '0;
            r_hi       <= '0;
            r_lo       <= '0;
            r_done     <= 1'b0;
            r_acc_hi   <= '0;
            r_acc_lo   <= '0;
            r_operand  <= '0;
            r_is_div   <= 1'b0;
            r_neg_q    <= 1'b0;
            r_neg_r    <= 1'b0;
            r_div_zero <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_state    <= RUN;
                        r_cnt      <= '0;
                        r_is_div   <= w_is_div;
                        r_neg_q    <= w_a_neg ^ w_b_neg;
                        r_neg_r    <= w_a_neg;
                        r_div_zero <= (srcb == '0);
                        r_acc_hi   <= '0;
                        if (w_is_div) begin
                            r_acc_lo  <= w_a_mag;
                            r_operand <= w_b_mag;
                        end else begin
                            r_acc_lo  <= w_b_mag;
                            r_operand <= w_a_mag;
                        end
                    end else if (!start) begin
                        // Any start, even one that is ignored, suppresses moves.
                        if (mthi) r_hi <= srca;
                        if (mtlo) r_lo <= srca;
                    end
                end
                RUN: begin
                    if (flush) begin
                        r_state <= IDLE;
                    end else begin
                        r_acc_hi <= w_step_hi;
                        r_acc_lo <= w_step_lo;
                        r_cnt    <= r_cnt + 1'b1;
                        if (r_cnt == CNT_W'(WIDTH - 1)) begin
                            r_state <= FIXUP;
                        end
                    end
                end
                FIXUP: begin
                    r_state <= IDLE;
                    if (!flush) begin
                        r_hi   <= w_res_hi;
                        r_lo   <= w_res_lo;
                        r_done <= 1'b1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign busy = (r_state != IDLE);
    assign done = r_done;
    assign hi   = r_hi;
    assign lo   = r_lo;

endmodule

// File: tb/tb_muldiv_unit.sv
// -----------------------------------------------------------------------------
// tb_muldiv_unit
// Directed vectors with hand-computed expected values for muldiv_unit.
// Divide vectors are exercised when MULDIV_DIVIDE_EN is defined; otherwise the
// bench confirms that a divide start is ignored.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_muldiv_unit;
    import muldiv_pkg::*;

    logic        ph1;
    logic        reset;
    logic        start;
    logic [1:0]  op;
    logic [31:0] srca;
    logic [31:0] srcb;
    logic        mthi;
    logic        mtlo;
    logic        flush;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    int n_checks = 0;
    int n_fail   = 0;

    muldiv_unit #(.WIDTH(32)) dut (
        .ph1   (ph1),
        .reset (reset),
        .start (start),
        .op    (op),
        .srca  (srca),
        .srcb  (srcb),
        .mthi  (mthi),
        .mtlo  (mtlo),
        .flush (flush),
        .busy  (busy),
        .done  (done),
        .hi    (hi),
        .lo    (lo)
    );

    initial ph1 = 1'b0;
    always #5 ph1 = ~ph1;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
        end
    endtask

    // Advance one edge and sample 1 ns after it.
    task automatic tick();
        @(posedge ph1);
        #1;
    endtask

    // Issue an op, optionally inject an ignored start+mthi+mtlo on RUN cycle
    // `inject`, wait (bounded) for done and check latency, busy and HI/LO.
    // Returns in the done cycle so a following call starts back-to-back.
    task automatic run_op(input string tag, input logic [1:0] o,
                          input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp_hi, input logic [31:0] exp_lo,
                          input int inject);
        int cycles;
        bit got;
        bit busy_drop;
        start = 1'b1; op = o; srca = a; srcb = b;
        tick();
        start = 1'b0;
        check({tag, ".busy"}, 32'(busy), 32'd1);
        cycles = 0; got = 1'b0; busy_drop = 1'b0;
        while (!got && cycles < 40) begin
            if (inject != 0 && cycles == inject) begin
                start = 1'b1; mthi = 1'b1; mtlo = 1'b1;
                op = MD_MULTU; srca = 32'hDEAD_BEEF; srcb = 32'd5;
            end
            tick();
            start = 1'b0; mthi = 1'b0; mtlo = 1'b0;
            cycles++;
            if (done) got = 1'b1;
            else if (!busy) busy_drop = 1'b1;
        end
        check({tag, ".latency"}, 32'(cycles), 32'd33);
        check({tag, ".busy_drop"}, 32'(busy_drop), 32'd0);
        check({tag, ".hi"}, hi, exp_hi);
        check({tag, ".lo"}, lo, exp_lo);
    endtask

    initial begin
        int n_done;
        reset = 1'b1; start = 1'b0; op = 2'b00; srca = '0; srcb = '0;
        mthi = 1'b0; mtlo = 1'b0; flush = 1'b0;

        // Reset state
        tick(); tick();
        check("rst.hi", hi, 32'h0);
        check("rst.lo", lo, 32'h0);
        check("rst.busy", 32'(busy), 32'd0);
        check("rst.done", 32'(done), 32'd0);
        reset = 1'b0;
        tick();

        // Multiply vectors; the second one sees an ignored start+moves mid-run,
        // the third is issued in the done cycle of the second.
        run_op("multu_max", MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
               32'hFFFF_FFFE, 32'h0000_0001, 0);
        run_op("mult_neg", MD_MULT, 32'hFFFF_FFFD, 32'd7,
               32'hFFFF_FFFF, 32'hFFFF_FFEB, 12);
        run_op("b2b_multu", MD_MULTU, 32'h0001_0000, 32'h0001_0000,
               32'h0000_0001, 32'h0000_0000, 0);
        run_op("mult_mixed", MD_MULT, 32'h7FFF_FFFF, 32'hFFFF_FFFF,
               32'hFFFF_FFFF, 32'h8000_0001, 0);

`ifdef MULDIV_DIVIDE_EN
        run_op("div_neg", MD_DIV, 32'hFFFF_FFF9, 32'd2,
               32'hFFFF_FFFF, 32'hFFFF_FFFD, 0);
        run_op("divu_zero", MD_DIVU, 32'd100, 32'd0,
               32'h0000_0064, 32'hFFFF_FFFF, 0);
        run_op("div_ovf", MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF,
               32'h0000_0000, 32'h8000_0000, 0);
`endif

        // Moves in IDLE: both together, then separately.
        mthi = 1'b1; mtlo = 1'b1; srca = 32'h0000_A5A5;
        tick();
        mthi = 1'b0; mtlo = 1'b0;
        check("mv_both.hi", hi, 32'h0000_A5A5);
        check("mv_both.lo", lo, 32'h0000_A5A5);
        mthi = 1'b1; srca = 32'h0000_1234;
        tick();
        mthi = 1'b0;
        mtlo = 1'b1; srca = 32'h0000_5678;
        tick();
        mtlo = 1'b0;
        check("mthi", hi, 32'h0000_1234);
        check("mtlo", lo, 32'h0000_5678);

        // Flush on the tenth RUN cycle of mult 2x3.
        start = 1'b1; op = MD_MULT; srca = 32'd2; srcb = 32'd3;
        tick();
        start = 1'b0;
        for (int i = 0; i < 9; i++) tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("flush.busy", 32'(busy), 32'd0);
        n_done = 0;
        for (int i = 0; i < 30; i++) begin
            if (done) n_done++;
            tick();
        end
        check("flush.no_done", 32'(n_done), 32'd0);
        check("flush.hi", hi, 32'h0000_1234);
        check("flush.lo", lo, 32'h0000_5678);

`ifdef MULDIV_DIVIDE_EN
        run_op("divu", MD_DIVU, 32'd10, 32'd3, 32'd1, 32'd3, 0);
        mthi = 1'b1; mtlo = 1'b1; srca = 32'h0000_1234;
        tick();
        mthi = 1'b0; mtlo = 1'b0;
`else
        // Divide start is ignored in the multiply-only build.
        start = 1'b1; op = MD_DIVU; srca = 32'd10; srcb = 32'd3;
        tick();
        start = 1'b0;
        check("nodiv.busy", 32'(busy), 32'd0);
        n_done = 0;
        for (int i = 0; i < 35; i++) begin
            if (done || busy) n_done++;
            tick();
        end
        check("nodiv.no_activity", 32'(n_done), 32'd0);
        check("nodiv.hi", hi, 32'h0000_1234);
        check("nodiv.lo", lo, 32'h0000_5678);
`endif

        // Asynchronous reset mid-RUN, sampled between clock edges.
        start = 1'b1; op = MD_MULTU; srca = 32'h0001_2345; srcb = 32'h0000_1000;
        tick();
        start = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        #2 reset = 1'b1;
        #1;
        check("areset.hi", hi, 32'h0);
        check("areset.lo", lo, 32'h0);
        check("areset.busy", 32'(busy), 32'd0);
        check("areset.done", 32'(done), 32'd0);
        #1 reset = 1'b0;
        tick();

        run_op("post_reset", MD_MULTU, 32'd6, 32'd7, 32'd0, 32'd42, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
